// File: rtl/uart_tx_serializer_if.sv
// Word handshake between the TX FIFO (master) and the UART serializer (slave).
// Signals: data_i word, valid_i word present, ready_o serializer can accept.
interface uart_tx_serializer_if #(
    parameter int DATASIZE = 20
);
    logic [DATASIZE-1:0] data_i;
    logic                valid_i;
    logic                ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATASIZE data bits LSB-first, stop bit.
// Ports: avl_clk_i, avl_reset_n_i (async low), bus (data/valid/ready slave),
//        clk_per_bit_i bit period (0 acts as 1), tx_o line, busy_o, done_o pulse.
module uart_tx_serializer #(
    parameter int DATASIZE = 20,
    parameter int DIVW     = 16
) (
    input  logic                 avl_clk_i,
    input  logic                 avl_reset_n_i,
    uart_tx_serializer_if.slave  bus,
    input  logic [DIVW-1:0]      clk_per_bit_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int IDXW = $clog2(DATASIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [DIVW-1:0]     cnt_q, cnt_d;
    logic [DIVW-1:0]     per_q, per_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [DATASIZE-1:0] shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                bit_end;

    always_ff @(posedge avl_clk_i or negedge avl_reset_n_i) begin
        if (!avl_reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // per_q is never 0 outside IDLE, so per_q-1 is the last count of a bit.
    assign bit_end = (cnt_q == per_q - DIVW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    shift_d = bus.data_i;
                    per_d   = (clk_per_bit_i == '0) ? DIVW'(1) : clk_per_bit_i;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDXW'(DATASIZE - 1)) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIVW'(1);
                end
            end
        endcase

        // Line level is decoded from the next state so tx_o comes off a flop.
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end else begin
            tx_d = 1'b1;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign tx_o        = tx_q;
    assign done_o      = done_q;

    a_done_ready: assert property (@(posedge avl_clk_i)
        disable iff (!avl_reset_n_i) done_o |-> bus.ready_o);
    a_busy_ready: assert property (@(posedge avl_clk_i)
        disable iff (!avl_reset_n_i) busy_o == !bus.ready_o);
    a_tx_high: assert property (@(posedge avl_clk_i)
        disable iff (!avl_reset_n_i)
        (state_q == IDLE || state_q == STOP) |-> tx_o);
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized self-checking bench for uart_tx_serializer (DATASIZE=8).
// Expected line waveforms come from a bit-list model of the UART frame.
module tb_uart_tx_serializer;
    localparam int DS = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] cpb;
    logic          tx;
    logic          busy;
    logic          done;
    int            checks;
    int            failures;

    uart_tx_serializer_if #(.DATASIZE(DS)) bus ();

    uart_tx_serializer #(.DATASIZE(DS), .DIVW(DW)) dut (
        .avl_clk_i     (clk),
        .avl_reset_n_i (rst_n),
        .bus           (bus.slave),
        .clk_per_bit_i (cpb),
        .tx_o          (tx),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_vs_ready", busy, !bus.ready_o);
            if (done) check("done_implies_ready", bus.ready_o, 1);
        end
    end

    // Called just after the transfer edge; checks every line cycle of the
    // frame, then the done cycle. disturb pokes inputs during data bits.
    task automatic expect_frame(input logic [DS-1:0] d, input logic [DW-1:0] p,
                                input bit disturb);
        int   pe;
        logic q[$];
        pe = (p == 0) ? 1 : int'(p);
        for (int i = 0; i < pe; i++) q.push_back(1'b0);
        for (int b = 0; b < DS; b++)
            for (int i = 0; i < pe; i++) q.push_back(d[b]);
        for (int i = 0; i < pe; i++) q.push_back(1'b1);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            check("tx_bit", tx, q[k]);
            check("ready_busy", bus.ready_o, 0);
            check("done_early", done, 0);
            if (disturb && k == 2 * pe) begin
                bus.data_i  = ~d;
                cpb         = 16'd7;
                bus.valid_i = 1'b1;
            end
            if (disturb && k == 6 * pe) bus.valid_i = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_tx", tx, 1);
        check("done_ready", bus.ready_o, 1);
        check("done_busy", busy, 0);
    endtask

    task automatic start(input logic [DS-1:0] d, input logic [DW-1:0] p);
        @(negedge clk);
        check("ready_pre", bus.ready_o, 1);
        bus.data_i  = d;
        cpb         = p;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    initial begin
        logic [DS-1:0] rd;
        logic [DW-1:0] rp;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        cpb         = '0;

        repeat (10) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_ready", bus.ready_o, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx", tx, 1);

        start(8'hA5, 16'd4);
        expect_frame(8'hA5, 16'd4, 1'b0);
        @(negedge clk);
        check("done_width", done, 0);

        start(8'h01, 16'd0);
        expect_frame(8'h01, 16'd0, 1'b0);
        start(8'h01, 16'd1);
        expect_frame(8'h01, 16'd1, 1'b0);

        // valid_i held high across the done cycle: second word taken there.
        @(negedge clk);
        bus.data_i  = 8'h55;
        cpb         = 16'd2;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.data_i = 8'h0F;
        expect_frame(8'h55, 16'd2, 1'b0);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        expect_frame(8'h0F, 16'd2, 1'b0);

        start(8'h96, 16'd3);
        expect_frame(8'h96, 16'd3, 1'b1);
        @(negedge clk);
        check("no_extra_xfer", busy, 0);

        start(8'hC3, 16'd300);
        expect_frame(8'hC3, 16'd300, 1'b0);

        // Abort during data bit 3 (bit value 0) with P=3.
        start(8'hC3, 16'd3);
        repeat (14) @(negedge clk);
        check("pre_abort_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_ready", bus.ready_o, 1);
        check("abort_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        start(8'h3C, 16'd3);
        expect_frame(8'h3C, 16'd3, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rd = DS'($urandom);
            rp = DW'($urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start(rd, rp);
            expect_frame(rd, rp, n[0]);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
